// File: rtl/or_accum.sv
// Registered OR unit: PAIR mode returns a|b per beat, FRAME mode folds a sticky OR
// across up to DEPTH beats. Valid/ready on both sides; out_any is the OR-reduction of out.
module or_accum #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             last,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_any,
  output logic [CW-1:0]    out_count,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             out_any_q;
  logic [CW-1:0]    out_cnt_q, out_cnt_d;
  logic             mode_q, mode_d;
  logic             accept;
  logic [WIDTH-1:0] pair_or;
  logic [WIDTH-1:0] nacc;
  logic [CW-1:0]    ncnt;

  assign in_ready  = rst_n & ((state_q != HOLD) | out_ready);
  assign accept    = in_valid & in_ready;
  assign pair_or   = a | b;
  assign nacc      = acc_q | pair_or;
  assign ncnt      = cnt_q + ONE_C;

  assign out       = out_q;
  assign out_any   = out_any_q;
  assign out_count = out_cnt_q;
  assign out_valid = (state_q == HOLD);

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    out_d     = out_q;
    out_cnt_d = out_cnt_q;
    mode_d    = mode_q;
    // A new frame starts from IDLE, or from HOLD on the same edge the result leaves.
    if (accept && (state_q == IDLE || state_q == HOLD)) begin
      mode_d = mode;
      if (!mode || last || DEPTH == 1) begin
        out_d     = pair_or;
        out_cnt_d = ONE_C;
        acc_d     = '0;
        cnt_d     = '0;
        state_d   = HOLD;
      end else begin
        acc_d   = pair_or;
        cnt_d   = ONE_C;
        state_d = ACCUM;
      end
    end else if (state_q == HOLD && out_ready) begin
      state_d = IDLE;
    end else if (state_q == ACCUM && accept) begin
      // The DEPTH-th beat closes the frame whether or not last is set.
      if (!mode_q || ncnt == DEPTH_C || last) begin
        out_d     = nacc;
        out_cnt_d = ncnt;
        acc_d     = '0;
        cnt_d     = '0;
        state_d   = HOLD;
      end else begin
        acc_d = nacc;
        cnt_d = ncnt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      out_q     <= '0;
      out_any_q <= 1'b0;
      out_cnt_q <= '0;
      mode_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      out_q     <= out_d;
      out_any_q <= |out_d;
      out_cnt_q <= out_cnt_d;
      mode_q    <= mode_d;
    end
  end

endmodule

// File: doc/or_accum.md
# or_accum

Parametrised, registered successor to the combinational `Or` gate for the Hack FPGA datapath. It ORs two WIDTH-bit operands per accepted beat and operates in one of two modes. In PAIR mode it returns each `a|b` as its own result. In FRAME mode it accumulates a running OR across up to DEPTH beats and emits one sticky result. It sits between a valid/ready producer (ALU/flag logic, test stimulus) and a valid/ready consumer, and provides the OR-reduction `out_any` (Or8Way/Or16Way equivalent) alongside the word result.

## Interface
- `WIDTH`, default 16: operand and result width in bits; must be ≥ 1.
- `DEPTH`, default 4: maximum beats per FRAME-mode result; must be ≥ 1. `CW = $clog2(DEPTH+1)`.

- `clk`  in  1  — the single clock; all state updates on its rising edge.
- `rst_n`  in  1  — reset, synchronous and active-low.
- `mode`  in  1  — 0 = PAIR, 1 = FRAME; sampled only on the first beat of a frame.
- `a`  in  WIDTH  — operand A.
- `b`  in  WIDTH  — operand B.
- `last`  in  1  — in FRAME mode, marks the accepted beat as the final beat of the frame; ignored in PAIR mode.
- `in_valid`  in  1  — input beat present.
- `in_ready`  out  1  — block accepts a beat. A beat is accepted when `in_valid & in_ready`.
- `out`  out  WIDTH  — result word.
- `out_any`  out  1  — `|out`.
- `out_count`  out  CW  — number of beats folded into `out`.
- `out_valid`  out  1  — result present.
- `out_ready`  in  1  — consumer accepts the result. The result is transferred when `out_valid & out_ready`.

## Operation
- States:
  - IDLE: no partial frame.
  - ACCUM: FRAME mode, partial frame held in `acc`/`cnt`.
  - HOLD: result presented.
- `in_ready = rst_n & (state != HOLD | out_ready)`. This is combinational, and its value is 0 whenever `rst_n` is low.
- Accepted beat in IDLE, or in HOLD with `out_ready=1` (either case starts a new frame):
  - Latch `mode` into `mode_q`.
  - If `mode=0`, or `mode=1` and (`last=1` or DEPTH=1): load `out = a|b`, `out_count = 1`, go to HOLD.
  - Otherwise: `acc = a|b`, `cnt = 1`, go to ACCUM.
- Accepted beat in ACCUM:
  - Compute `nacc = acc | a | b` and `ncnt = cnt + 1`.
  - If `ncnt == DEPTH` or `last=1`: `out = nacc`, `out_count = ncnt`, go to HOLD.
  - Otherwise: `acc = nacc`, `cnt = ncnt`, stay in ACCUM.
  - `mode` is ignored in ACCUM; `mode_q` governs the frame.
- No accepted beat in ACCUM: hold `acc`/`cnt` indefinitely; there is no timeout.
- HOLD with `out_ready=1` and no accepted beat: go to IDLE and deassert `out_valid`.
- HOLD with `out_ready=0`: `out`, `out_any`, `out_count`, `out_valid` stay stable, and no beat is accepted.
- `out`/`out_count` keep their last value after transfer until the next result loads. `out_any` always tracks `out`.
- `acc`/`cnt` clear to 0 whenever a result is loaded.
- `cnt` never exceeds DEPTH. The DEPTH-th beat always closes the frame, regardless of `last`.

## Timing
- Reset (`rst_n=0` at a rising edge):
  - State → IDLE.
  - `out=0`, `out_any=0`, `out_count=0`, `out_valid=0`, `acc=0`, `cnt=0`.
  - `in_ready=0` while `rst_n` is low.
- Reset mid-frame or during HOLD discards the partial accumulation and the pending result; the beat presented on the reset edge is not accepted.
- Latency: `out_valid` rises on the edge that accepts the closing beat, so the result is visible the cycle after that beat's accept cycle.
- Throughput: with `out_ready` held high, PAIR mode delivers one result per cycle, and FRAME mode delivers one result per closing beat with no bubble. The result transfer and the next beat's acceptance occur on the same edge.
- `out_any` is registered together with `out`; no combinational path from `a`/`b` reaches any output.
- Arithmetic: all OR is bitwise over WIDTH bits. `cnt` is CW bits and saturates structurally at DEPTH.

## Test plan
- **Reset:** hold `rst_n=0` for 2 cycles with `in_valid=1`, `a=FFFF` → `in_ready=0`, `out_valid=0`, `out=0000`, `out_count=0`. After `rst_n=1`, `in_ready=1` in the next cycle.
- **PAIR truth table, back-to-back, `out_ready=1`:**
  - Input pairs (a/b): 0000/0000, 00FF/FF00, 8000/0001, FFFF/FFFF.
  - Expected `out`: 0000, FFFF, 8001, FFFF, one per cycle.
  - Expected `out_any`: 0, 1, 1, 1. `out_count=1` for every result.
- **FRAME full depth (DEPTH=4):**
  - Beats: (0001,0000), (0000,0010), (0100,0000), (0000,8000), `last=0` throughout.
  - Expected: a single result `out=8111`, `out_any=1`, `out_count=4`, valid one cycle after the 4th accept.
  - `mode` toggled to 0 mid-frame has no effect.
- **FRAME early `last`:** beats (0000,0000), then (0000,0000) with `last=1` → `out=0000`, `out_any=0`, `out_count=2`.
- **Backpressure:**
  - Hold `out_ready=0` for 5 cycles with a result pending → `out` stable, `in_ready=0`, no beats accepted.
  - Raise `out_ready=1` with `in_valid=1` → result transferred and the new beat accepted on the same edge.
- **Reset mid-frame:** in FRAME mode, after beats (F000,0000) and (0F00,0000), pulse `rst_n=0` for 1 cycle. Then send (0000,000F) with `last=1` → `out=000F`, `out_count=1`.
